// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage divide sequencer.
//   - ALU control encodings that start a divide (DIV / DIVU) plus a NOP code.
//   - Divider state encoding, exported so hazard and trace logic can decode it.
package div_sequencer_pkg;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage : div_sequencer_pkg

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the EX stage (DIV / DIVU).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   alucontrolE  EX-stage ALU op; DIV starts a signed, DIVU an unsigned divide
//   a, b         dividend / divisor (forwarded rs / rt)
//   stallE       EX held by another source; keeps a finished result in DONE
//   flushE       EX flush; abandons any divide in flight
//   stall_div    hold request for IF/ID/EX while the divide is in progress
//   ready        result valid this cycle
//   result       {remainder, quotient} -> {hi, lo}
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           alucontrolE,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 stallE,
  input  logic                 flushE,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*WIDTH:0]      sr_q;      // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
  logic [WIDTH-1:0]      dvs_q;     // divisor magnitude
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic                  ready_q;
  logic [2*WIDTH-1:0]    result_q;

  logic                  is_div;
  logic                  is_signed;
  logic                  start;
  logic [WIDTH-1:0]      mag_a;
  logic [WIDTH-1:0]      mag_b;
  logic [2*WIDTH:0]      sr_shift;
  logic                  sub_ok;
  logic [WIDTH:0]        trial;
  logic [2*WIDTH:0]      sr_next;
  logic [WIDTH-1:0]      quot_raw;
  logic [WIDTH-1:0]      rem_raw;
  logic [WIDTH-1:0]      quot_fix;
  logic [WIDTH-1:0]      rem_fix;

  assign is_div    = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_DIVU_OP);
  assign is_signed = (alucontrolE == EXE_DIV_OP);
  assign start     = is_div && !flushE;

  // Signed mode works on magnitudes; the most negative value maps onto
  // itself, which is its correct unsigned magnitude.
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // One restoring step: shift, trial-subtract from the upper half, keep the
  // difference and shift in a 1 only when it does not go negative.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    sr_shift = {sr_q[2*WIDTH-1:0], 1'b0};
    sub_ok   = (sr_shift[2*WIDTH:WIDTH] >= {1'b0, dvs_q});
    trial    = sr_shift[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    sr_next  = sr_shift;
    if (sub_ok) begin
      sr_next = {trial, sr_shift[WIDTH-1:1], 1'b1};
    end
  end

  assign quot_raw = sr_next[WIDTH-1:0];
  assign rem_raw  = sr_next[2*WIDTH-1:WIDTH];
  assign quot_fix = q_neg_q ? -quot_raw : quot_raw;
  assign rem_fix  = r_neg_q ? -rem_raw  : rem_raw;

  // A flush removes the request in the same cycle so the front end is not
  // held for an instruction that is being discarded.
  assign stall_div = !flushE &&
                     (((state_q == DIV_IDLE) && start) ||
                      (state_q == DIV_ZERO) || (state_q == DIV_RUN));

  assign ready  = ready_q;
  assign result = result_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (flushE) begin
      state_q <= DIV_IDLE;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (b == '0) begin
              state_q <= DIV_ZERO;
            end else begin
              state_q <= DIV_RUN;
              cnt_q   <= '0;
              sr_q    <= {{(WIDTH+1){1'b0}}, mag_a};
              dvs_q   <= mag_b;
              q_neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_q <= is_signed && a[WIDTH-1];
            end
          end
        end
        DIV_ZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= DIV_DONE;
        end
        DIV_RUN: begin
          sr_q  <= sr_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            result_q <= {rem_fix, quot_fix};
            ready_q  <= 1'b1;
            state_q  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          // Held in DONE while EX is stalled elsewhere; the still-present
          // DIV op must not restart because only IDLE looks at start.
          if (!stallE) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  alucontrolE;
  logic [31:0] a;
  logic [31:0] b;
  logic        stallE;
  logic        flushE;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .alucontrolE (alucontrolE),
    .a           (a),
    .b           (b),
    .stallE      (stallE),
    .flushE      (flushE),
    .stall_div   (stall_div),
    .ready       (ready),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for ready, recording cycles taken and whether stall_div
  // stayed high in every cycle before ready.
  task automatic wait_ready(output int cycles, output logic stall_ok);
    cycles   = 0;
    stall_ok = 1'b1;
    while (ready !== 1'b1 && cycles < 100) begin
      if (stall_div !== 1'b1) stall_ok = 1'b0;
      tick();
      cycles++;
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
    int   cycles;
    logic stall_ok;
    alucontrolE = op;
    a = av;
    b = bv;
    stallE = 1'b0;
    flushE = 1'b0;
    #1;
    wait_ready(cycles, stall_ok);
    check({tag, " latency"},    64'(cycles), 64'(exp_lat));
    check({tag, " stall"},      64'(stall_ok), 64'd1);
    check({tag, " result"},     result, exp);
    check({tag, " stall_done"}, 64'(stall_div), 64'd0);
    alucontrolE = EXE_NOP_OP;
    tick();
    check({tag, " ready_clr"},  64'(ready), 64'd0);
    check({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    int   cycles;
    logic stall_ok;
    logic seen_ready;

    rst = 1'b0;
    alucontrolE = EXE_NOP_OP;
    a = '0;
    b = '0;
    stallE = 1'b0;
    flushE = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready",  64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    check("reset stall",  64'(stall_div), 64'd0);
    rst = 1'b1;
    tick();

    // Basic signed/unsigned cases: {remainder, quotient}
    run_div("div 100/7",    EXE_DIV_OP,  32'd100,        32'd7,          {32'd2,        32'd14},         33);
    run_div("div -7/2",     EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("divu -7/2",    EXE_DIVU_OP, 32'hFFFF_FFF9,  32'd2,          {32'd1,        32'h7FFF_FFFC},  33);
    run_div("div min/-1",   EXE_DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,        32'h8000_0000},  33);
    run_div("divu max/2",   EXE_DIVU_OP, 32'hFFFF_FFFF,  32'd2,          {32'd1,        32'h7FFF_FFFF},  33);
    run_div("div 7/-100",   EXE_DIV_OP,  32'd7,          32'hFFFF_FF9C,  {32'd7,        32'd0},          33);
    run_div("div by zero",  EXE_DIV_OP,  32'd123,        32'd0,          64'd0,                           2);

    // DONE held by stallE with the DIV op still present: no restart.
    alucontrolE = EXE_DIV_OP;
    a = 32'hFFFF_FF9C;   // -100
    b = 32'd7;
    stallE = 1'b0;
    #1;
    wait_ready(cycles, stall_ok);
    check("hold latency", 64'(cycles), 64'd33);
    check("hold first result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold ready",  64'(ready), 64'd1);
      check("hold result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
      check("hold stall",  64'(stall_div), 64'd0);
    end
    stallE = 1'b0;
    alucontrolE = EXE_NOP_OP;
    tick();
    check("release ready",  64'(ready), 64'd0);
    check("release stall",  64'(stall_div), 64'd0);
    check("release result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Flush ten cycles into a divide.
    alucontrolE = EXE_DIV_OP;
    a = 32'd100;
    b = 32'd7;
    #1;
    for (int i = 0; i < 10; i++) tick();
    check("flush pre stall", 64'(stall_div), 64'd1);
    flushE = 1'b1;
    alucontrolE = EXE_NOP_OP;
    #1;
    check("flush stall drop", 64'(stall_div), 64'd0);
    tick();
    flushE = 1'b0;
    #1;
    check("flush idle stall", 64'(stall_div), 64'd0);
    check("flush idle ready", 64'(ready), 64'd0);
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1) seen_ready = 1'b1;
    end
    check("flush no ready", 64'(seen_ready), 64'd0);
    check("flush result kept", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Asynchronous reset in the middle of RUN.
    alucontrolE = EXE_DIV_OP;
    a = 32'd100;
    b = 32'd7;
    #1;
    for (int i = 0; i < 5; i++) tick();
    alucontrolE = EXE_NOP_OP;
    rst = 1'b0;
    #1;
    check("midrun rst ready",  64'(ready), 64'd0);
    check("midrun rst result", result, 64'd0);
    check("midrun rst stall",  64'(stall_div), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post rst ready", 64'(ready), 64'd0);

    run_div("div after rst", EXE_DIV_OP, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div_sequencer
